dror_point_scheduler: RTL and testbench

- Upstream control stage for dror_validator_core.
- For each point of a cloud held in a wide point memory, it loads the point under test and resets the core.
- It then streams the cloud one memory row (DISTANCE_MODULES points) per cycle into the core's comparison-point buses, and collects the core's inlier/outlier verdict.
- It emits one verdict per point on a valid/ready result interface to the downstream filtered-cloud writer.

---
 rtl/dror_point_scheduler_pkg.sv | 21 ++
 rtl/dror_point_scheduler_if.sv | 24 ++
 rtl/dror_lane_masker.sv | 68 ++++++
 rtl/dror_point_scheduler.sv | 210 +++++++++++++++++++++
 tb/tb_dror_point_scheduler.sv | 316 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/dror_point_scheduler_pkg.sv
// Shared types and helpers for the DROR validator datapath.
// Used by the point scheduler, its lane masker and the core.
package dror_pkg;

  typedef enum logic [2:0] {
    IDLE,
    FETCH_P,
    LOAD_P,
    STREAM,
    DRAIN,
    REPORT,
    DONE
  } state_t;

  localparam logic [63:0] SENTINEL = '1;

  function automatic int dm_shift(input int dm);
    return $clog2(dm);
  endfunction

endpackage

// File: rtl/dror_point_scheduler_if.sv
// Verdict handshake from the point scheduler to the
// filtered-cloud writer.
interface dror_point_scheduler_if #(
  parameter int N = 16
);
  logic           o_result_valid;
  logic           i_result_ready;
  logic [2*N-1:0] o_result_index;
  logic           o_result_inlier;

  modport master (
    output o_result_valid,
    output o_result_index,
    output o_result_inlier,
    input  i_result_ready
  );

  modport slave (
    input  o_result_valid,
    input  o_result_index,
    input  o_result_inlier,
    output i_result_ready
  );
endinterface

// File: rtl/dror_lane_masker.sv
// Replaces out-of-cloud lanes and the point's own lane with
// the sentinel, then registers the row onto the cp buses.
module dror_lane_masker
  import dror_pkg::*;
#(
  parameter int N      = 16,
  parameter int DM     = 8,
  parameter int ADDR_W = 12
) (
  input  logic            i_clock,
  input  logic            i_reset,
  input  logic            i_valid,
  input  logic [ADDR_W-1:0] i_row,
  input  logic [2*N-1:0]  i_size,
  input  logic [2*N-1:0]  i_self_idx,
  input  logic [N*DM-1:0] i_x,
  input  logic [N*DM-1:0] i_y,
  input  logic [N*DM-1:0] i_z,
  output logic [N*DM-1:0] o_x,
  output logic [N*DM-1:0] o_y,
  output logic [N*DM-1:0] o_z
);
  localparam int SHIFT = dm_shift(DM);
  localparam int W     = 2 * N;

  logic [W-1:0]    w_row_base;
  logic [N*DM-1:0] w_x;
  logic [N*DM-1:0] w_y;
  logic [N*DM-1:0] w_z;
  logic [N*DM-1:0] r_x;
  logic [N*DM-1:0] r_y;
  logic [N*DM-1:0] r_z;

  assign w_row_base =
    {{(W-ADDR_W){1'b0}}, i_row} << SHIFT;

  for (genvar k = 0; k < DM; k++) begin : g_lane
    logic [W-1:0] w_idx;
    logic         w_keep;
    assign w_idx  = w_row_base | W'(k);
    assign w_keep = i_valid
                 && (w_idx < i_size)
                 && (w_idx != i_self_idx);
    assign w_x[k*N +: N] = w_keep ?
      i_x[k*N +: N] : SENTINEL[N-1:0];
    assign w_y[k*N +: N] = w_keep ?
      i_y[k*N +: N] : SENTINEL[N-1:0];
    assign w_z[k*N +: N] = w_keep ?
      i_z[k*N +: N] : SENTINEL[N-1:0];
  end

  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      r_x <= '0;
      r_y <= '0;
      r_z <= '0;
    end else begin
      r_x <= w_x;
      r_y <= w_y;
      r_z <= w_z;
    end
  end

  assign o_x = r_x;
  assign o_y = r_y;
  assign o_z = r_z;

endmodule

// File: rtl/dror_point_scheduler.sv
// Walks every point of the cloud through dror_validator_core
// and reports one inlier/outlier verdict per point.
module dror_point_scheduler
  import dror_pkg::*;
#(
  parameter int N                = 16,
  parameter int DISTANCE_MODULES = 8,
  parameter int ADDR_W           = 12,
  parameter int CORE_LATENCY     = 4,
  parameter int DRAIN_SLACK      = 2
) (
  input  logic        i_clock,
  input  logic        i_reset,
  input  logic        i_start,
  input  logic [2*N-1:0] i_point_cloud_size,
  output logic        o_busy,
  output logic        o_done,
  output logic [ADDR_W-1:0] o_mem_addr,
  output logic        o_mem_rd,
  input  logic [N*DISTANCE_MODULES-1:0] i_mem_x,
  input  logic [N*DISTANCE_MODULES-1:0] i_mem_y,
  input  logic [N*DISTANCE_MODULES-1:0] i_mem_z,
  output logic [N-1:0] o_point_x,
  output logic [N-1:0] o_point_y,
  output logic [N-1:0] o_point_z,
  output logic [N*DISTANCE_MODULES-1:0] o_cp_x,
  output logic [N*DISTANCE_MODULES-1:0] o_cp_y,
  output logic [N*DISTANCE_MODULES-1:0] o_cp_z,
  output logic [2*N-1:0] o_point_cloud_size,
  output logic        o_core_reset,
  input  logic        i_inlier,
  input  logic        i_outlier,
  dror_point_scheduler_if.master res_if
);
  localparam int DM        = DISTANCE_MODULES;
  localparam int SHIFT     = dm_shift(DM);
  localparam int W         = 2 * N;
  localparam int DRAIN_CYC = CORE_LATENCY + DRAIN_SLACK;
  localparam int DW        = $clog2(DRAIN_CYC + 1);

  state_t r_state;
  state_t w_next;

  logic [W-1:0]      r_size;
  logic [W-1:0]      r_idx;
  logic [ADDR_W-1:0] r_row;
  logic [ADDR_W-1:0] r_data_row;
  logic              r_data_vld;
  logic [DW-1:0]     r_drain;
  logic              r_verdict;
  logic              r_busy;
  logic              r_done;
  logic [N-1:0]      r_px;
  logic [N-1:0]      r_py;
  logic [N-1:0]      r_pz;

  logic [W:0]         w_rows_m1;
  logic               w_last_row;
  logic               w_last_idx;
  logic               w_accept;
  logic               w_hs;
  logic               w_set;
  logic               w_verdict;
  logic               w_mask_vld;
  logic [SHIFT-1:0]   w_lane;
  logic [ADDR_W-1:0]  w_self_row;

  // Row count minus one, widened so ceil() cannot overflow.
  assign w_rows_m1 =
    (({1'b0, r_size} + (W+1)'(DM - 1)) >> SHIFT)
    - (W+1)'(1);
  assign w_last_row =
    ({{(W+1-ADDR_W){1'b0}}, r_row} == w_rows_m1);
  assign w_last_idx = (r_idx == r_size - W'(1));
  assign w_lane     = r_idx[SHIFT-1:0];
  assign w_self_row = r_idx[SHIFT +: ADDR_W];
  assign w_accept   = (r_state == IDLE) && i_start;
  assign w_hs       = (r_state == REPORT)
                   && res_if.i_result_ready;

  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) r_state <= IDLE;
    else          r_state <= w_next;
  end

  always_comb begin
    w_next    = r_state;
    w_set     = 1'b0;
    w_verdict = 1'b0;
    unique case (r_state)
      IDLE:
        if (i_start)
          w_next = (i_point_cloud_size == '0) ?
                   DONE : FETCH_P;
      FETCH_P: w_next = LOAD_P;
      LOAD_P:  w_next = STREAM;
      STREAM:
        if (i_inlier) begin
          w_next    = REPORT;
          w_set     = 1'b1;
          w_verdict = 1'b1;
        end else if (w_last_row) begin
          w_next = DRAIN;
        end
      DRAIN:
        if (i_inlier) begin
          w_next    = REPORT;
          w_set     = 1'b1;
          w_verdict = 1'b1;
        end else if (i_outlier ||
                     r_drain == DW'(DRAIN_CYC - 1)) begin
          w_next = REPORT;
          w_set  = 1'b1;
        end
      REPORT:
        if (res_if.i_result_ready)
          w_next = w_last_idx ? DONE : FETCH_P;
      DONE:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      r_size     <= '0;
      r_idx      <= '0;
      r_row      <= '0;
      r_data_row <= '0;
      r_data_vld <= 1'b0;
      r_drain    <= '0;
      r_verdict  <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_px       <= '0;
      r_py       <= '0;
      r_pz       <= '0;
    end else begin
      r_data_vld <= (r_state == STREAM);
      r_data_row <= r_row;
      r_done     <= (r_state == DONE);
      if (w_accept) begin
        r_size <= i_point_cloud_size;
        r_idx  <= '0;
        r_busy <= 1'b1;
      end else if (r_state == DONE) begin
        r_busy <= 1'b0;
      end
      if (w_hs && !w_last_idx)
        r_idx <= r_idx + W'(1);
      if (r_state == LOAD_P) begin
        r_px  <= i_mem_x[w_lane*N +: N];
        r_py  <= i_mem_y[w_lane*N +: N];
        r_pz  <= i_mem_z[w_lane*N +: N];
        r_row <= '0;
      end
      if (r_state == STREAM) begin
        r_row   <= r_row + ADDR_W'(1);
        r_drain <= '0;
      end
      if (r_state == DRAIN)
        r_drain <= r_drain + DW'(1);
      if (w_set)
        r_verdict <= w_verdict;
    end
  end

  // Rows still in flight when the verdict lands are dropped.
  assign w_mask_vld = r_data_vld
    && (r_state == STREAM || r_state == DRAIN);

  dror_lane_masker #(
    .N      (N),
    .DM     (DM),
    .ADDR_W (ADDR_W)
  ) u_masker (
    .i_clock    (i_clock),
    .i_reset    (i_reset),
    .i_valid    (w_mask_vld),
    .i_row      (r_data_row),
    .i_size     (r_size),
    .i_self_idx (r_idx),
    .i_x        (i_mem_x),
    .i_y        (i_mem_y),
    .i_z        (i_mem_z),
    .o_x        (o_cp_x),
    .o_y        (o_cp_y),
    .o_z        (o_cp_z)
  );

  assign o_busy             = r_busy;
  assign o_done             = r_done;
  assign o_point_x          = r_px;
  assign o_point_y          = r_py;
  assign o_point_z          = r_pz;
  assign o_point_cloud_size = r_size;
  assign o_mem_rd = (r_state == FETCH_P)
                 || (r_state == STREAM);
  assign o_mem_addr =
    (r_state == FETCH_P) ? w_self_row :
    (r_state == STREAM)  ? r_row : '0;
  assign o_core_reset = !((r_state == STREAM)
                       || (r_state == DRAIN));

  assign res_if.o_result_valid  = (r_state == REPORT);
  assign res_if.o_result_index  =
    (r_state == REPORT) ? r_idx : '0;
  assign res_if.o_result_inlier =
    (r_state == REPORT) && r_verdict;

endmodule

// File: tb/tb_dror_point_scheduler.sv
// Directed bench for dror_point_scheduler with a memory
// model, a core model and a transaction-level reference.
module tb_dror_point_scheduler;
  localparam int N  = 16;
  localparam int DM = 8;
  localparam int AW = 12;
  localparam int CL = 4;
  localparam int DS = 2;
  localparam int W  = 2 * N;
  localparam int BW = N * DM;
  localparam logic [N-1:0] SENT = '1;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic ready = 1'b1;
  logic inl = 1'b0;
  logic outl = 1'b0;
  logic [W-1:0] size_in = '0;
  logic busy, done, mrd, core_rst;
  logic [AW-1:0] maddr;
  logic [BW-1:0] mx = '0;
  logic [BW-1:0] my = '0;
  logic [BW-1:0] mz = '0;
  logic [BW-1:0] cpx, cpy, cpz;
  logic [N-1:0] px, py, pz;
  logic [W-1:0] psize;

  dror_point_scheduler_if #(.N(N)) u_if ();
  assign u_if.i_result_ready = ready;

  dror_point_scheduler #(
    .N(N), .DISTANCE_MODULES(DM), .ADDR_W(AW),
    .CORE_LATENCY(CL), .DRAIN_SLACK(DS)
  ) dut (
    .i_clock(clk), .i_reset(rst_n), .i_start(start),
    .i_point_cloud_size(size_in),
    .o_busy(busy), .o_done(done),
    .o_mem_addr(maddr), .o_mem_rd(mrd),
    .i_mem_x(mx), .i_mem_y(my), .i_mem_z(mz),
    .o_point_x(px), .o_point_y(py), .o_point_z(pz),
    .o_cp_x(cpx), .o_cp_y(cpy), .o_cp_z(cpz),
    .o_point_cloud_size(psize),
    .o_core_reset(core_rst),
    .i_inlier(inl), .i_outlier(outl),
    .res_if(u_if)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  task automatic chk(string nm, logic [BW-1:0] act,
                     logic [BW-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%0h exp=%0h", nm, act, exp);
    end
  endtask

  // Reference scenario state
  int cur_size = 0, mode = 0, inl_k = 0;
  int exp_idx = 0, results = 0, done_cnt = 0;
  int cyc = 0, done_cyc = 0, start_cyc = 0;
  int total_reads = 0, max_srow = 0, last_sread = 0;
  int first_gap = -1, scnt = 0, gap, rows, nr;
  int reads[$];
  bit srd1 = 0, srd2 = 0, cr1 = 1, live;
  int srow1 = 0, srow2 = 0;
  bit pv = 0, pr = 0, pinl = 0, pdone = 0;
  logic [W-1:0] pidx = '0;
  bit cap_en = 0;
  logic [BW-1:0] cap0 = '0, cap2 = '0;
  bit mrd_q = 0;
  int maddr_q = 0;

  function automatic logic [N-1:0] coord(int p, int a);
    case (a)
      0:       return N'(3 * p + 1);
      1:       return N'(5 * p + 2);
      default: return N'(7 * p + 3);
    endcase
  endfunction

  function automatic logic [BW-1:0] row_vec(
      int r, int a, bit masked);
    logic [BW-1:0] v;
    int p;
    v = '0;
    for (int k = 0; k < DM; k++) begin
      p = r * DM + k;
      if (masked && (p >= cur_size || p == exp_idx))
        v[k*N +: N] = SENT;
      else
        v[k*N +: N] = coord(p, a);
    end
    return v;
  endfunction

  // Memory answers one cycle after the read; core model
  always @(posedge clk) begin
    #1;
    if (mrd_q) begin
      mx = row_vec(maddr_q, 0, 0);
      my = row_vec(maddr_q, 1, 0);
      mz = row_vec(maddr_q, 2, 0);
    end
    if (!rst_n || core_rst) scnt = 0;
    else scnt++;
    inl  = (mode == 2) && (scnt == inl_k);
    outl = (mode == 1) && rst_n && !core_rst;
  end

  always @(negedge clk) begin
    if (!rst_n) begin
      srd1 = 0; srd2 = 0; cr1 = 1;
      pv = 0; pr = 0; pdone = 0; mrd_q = 0;
    end else begin
      cyc++;
      if (busy) begin
        live = srd2 && !cr1;
        chk("cp_x", cpx, live ? row_vec(srow2, 0, 1)
                              : {DM{SENT}});
        chk("cp_y", cpy, live ? row_vec(srow2, 1, 1)
                              : {DM{SENT}});
        chk("cp_z", cpz, live ? row_vec(srow2, 2, 1)
                              : {DM{SENT}});
        if (cap_en && live && srow2 == 0) begin
          if (exp_idx == 0) cap0 = cpx;
          if (exp_idx == 2) cap2 = cpx;
        end
        chk("size_out", psize, W'(cur_size));
      end
      if (mrd && !core_rst) begin
        chk("pt_x", px, coord(exp_idx, 0));
        chk("pt_y", py, coord(exp_idx, 1));
        chk("pt_z", pz, coord(exp_idx, 2));
        last_sread = cyc;
        if (int'(maddr) > max_srow) max_srow = maddr;
      end
      if (u_if.o_result_valid) begin
        chk("rep_core_rst", core_rst, 1);
        chk("rep_no_rd", mrd, 0);
        if (!pv) begin
          chk("res_idx", u_if.o_result_index,
              W'(exp_idx));
          chk("res_inl", u_if.o_result_inlier,
              (mode == 2));
          gap = cyc - last_sread;
          if (first_gap < 0) first_gap = gap;
          chk("res_gap", gap, mode == 0 ? CL + DS + 1 :
                              mode == 1 ? 2 : 1);
          rows = (cur_size + DM - 1) / DM;
          nr = (mode == 2 && inl_k < rows) ? inl_k : rows;
          chk("rd_count", reads.size(), nr + 1);
          if (reads.size() == nr + 1)
            for (int i = 0; i <= nr; i++)
              chk("rd_addr", reads[i],
                  i == 0 ? exp_idx / DM : i - 1);
        end
      end
      if (pv && !pr) begin
        chk("hold_valid", u_if.o_result_valid, 1);
        chk("hold_idx", u_if.o_result_index, pidx);
        chk("hold_inl", u_if.o_result_inlier, pinl);
      end
      if (mrd) begin
        reads.push_back(int'(maddr));
        total_reads++;
      end
      if (u_if.o_result_valid && ready) begin
        results++;
        exp_idx++;
        reads.delete();
      end
      if (done) begin
        chk("done_width", pdone, 0);
        chk("done_results", results, cur_size);
        done_cnt++;
        done_cyc = cyc;
      end
      srd2 = srd1; srow2 = srow1;
      srd1 = mrd && !core_rst; srow1 = maddr;
      cr1 = core_rst;
      pv = u_if.o_result_valid; pr = ready;
      pidx = u_if.o_result_index;
      pinl = u_if.o_result_inlier;
      pdone = done;
      mrd_q = mrd; maddr_q = maddr;
    end
  end

  task automatic kick(int sz, int md, int k);
    @(posedge clk); #1;
    cur_size = sz; mode = md; inl_k = k;
    exp_idx = 0; results = 0; reads.delete();
    size_in = W'(sz);
    start = 1'b1;
    start_cyc = cyc + 1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(int d0, int budget);
    int n;
    n = 0;
    while (done_cnt == d0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    chk("done_seen", done_cnt - d0, 1);
  endtask

  task automatic chk_reset();
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_rd", mrd, 0);
    chk("rst_addr", maddr, 0);
    chk("rst_core_rst", core_rst, 1);
    chk("rst_valid", u_if.o_result_valid, 0);
    chk("rst_idx", u_if.o_result_index, 0);
    chk("rst_cp", cpx, 0);
    chk("rst_pt", px, 0);
    chk("rst_size", psize, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int d0, r0, n;
    repeat (3) @(posedge clk);
    #1 chk_reset();
    rst_n = 1'b1;
    repeat (2) @(posedge clk);

    // Empty cloud
    d0 = done_cnt; r0 = total_reads;
    kick(0, 1, 0);
    wait_done(d0, 50);
    chk("sz0_delay", done_cyc - start_cyc, 2);
    chk("sz0_reads", total_reads - r0, 0);
    chk("sz0_results", results, 0);

    // Five points, core always votes outlier
    cap_en = 1;
    d0 = done_cnt;
    kick(5, 1, 0);
    wait_done(d0, 500);
    cap_en = 0;
    chk("sz5_results", results, 5);
    chk("sz5_cp_idx0", cap0,
        128'hFFFF_FFFF_FFFF_000D_000A_0007_0004_FFFF);
    chk("sz5_cp_idx2", cap2,
        128'hFFFF_FFFF_FFFF_000D_000A_FFFF_0004_0001);

    // Early inlier on the second streamed row
    max_srow = 0;
    d0 = done_cnt;
    kick(20, 2, 2);
    wait_done(d0, 2000);
    chk("sz20_results", results, 20);
    chk("sz20_max_row", max_srow, 1);

    // Silent core times out
    first_gap = -1;
    d0 = done_cnt;
    kick(3, 0, 0);
    wait_done(d0, 500);
    chk("silent_results", results, 3);
    chk("silent_gap", first_gap, 7);

    // Downstream back-pressure on the first verdict
    ready = 1'b0;
    d0 = done_cnt;
    kick(3, 1, 0);
    n = 0;
    while (!u_if.o_result_valid && n < 100) begin
      @(negedge clk); n++;
    end
    repeat (10) @(posedge clk);
    #1 ready = 1'b1;
    wait_done(d0, 500);
    chk("stall_results", results, 3);

    // Asynchronous abort while streaming point 3
    kick(8, 1, 0);
    n = 0;
    do begin
      @(negedge clk); #1; n++;
    end while (!(exp_idx == 3 && mrd && !core_rst)
               && n < 300);
    rst_n = 1'b0;
    #1 chk_reset();
    d0 = done_cnt;
    repeat (3) @(posedge clk);
    chk("abort_no_done", done_cnt - d0, 0);
    chk("abort_results", results, 3);
    #1 rst_n = 1'b1;
    repeat (2) @(posedge clk);
    d0 = done_cnt;
    kick(4, 1, 0);
    wait_done(d0, 500);
    chk("restart_results", results, 4);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
